// File: rtl/uart_cmd_dispatcher_pkg.sv
// Shared command codes, reply bases, reason codes and state encodings for the
// UART command dispatcher.
package uart_cmd_dispatcher_pkg;

   localparam int unsigned NIB_W  = 4;
   localparam int unsigned BYTE_W = 8;

   localparam logic [NIB_W-1:0] CMD_ON   = 4'h6;
   localparam logic [NIB_W-1:0] CMD_OFF  = 4'hD;
   localparam logic [NIB_W-1:0] CMD_TOG  = 4'h9;
   localparam logic [NIB_W-1:0] CMD_PING = 4'h0;

   localparam logic [BYTE_W-1:0] REPLY_ACK  = 8'hA0;
   localparam logic [BYTE_W-1:0] REPLY_NACK = 8'hE0;

   localparam logic [NIB_W-1:0] RSN_NONE = 4'd0;
   localparam logic [NIB_W-1:0] RSN_HAM  = 4'd1;
   localparam logic [NIB_W-1:0] RSN_ADDR = 4'd2;
   localparam logic [NIB_W-1:0] RSN_CODE = 4'd3;
   localparam logic [NIB_W-1:0] RSN_PAR  = 4'd4;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_WAIT_CMD = 3'd1;
   localparam logic [2:0] S_EXEC     = 3'd2;
   localparam logic [2:0] S_SEND     = 3'd3;
   localparam logic [2:0] S_WAIT_TX  = 3'd4;

   // One decoded frame byte with its qualifying flags.
   typedef struct packed {
      logic [NIB_W-1:0] nibble;
      logic             ham_err;
      logic             par_err;
   } field_t;

   function automatic logic is_known_cmd(input logic [NIB_W-1:0] code);
      return (code == CMD_ON) || (code == CMD_OFF) || (code == CMD_TOG) || (code == CMD_PING);
   endfunction

   function automatic logic [BYTE_W-1:0] sat_add(input logic [BYTE_W-1:0] count,
                                                 input logic [1:0]        inc);
      logic [BYTE_W:0] sum;
      sum = {1'b0, count} + {7'b0, inc};
      return sum[BYTE_W] ? 8'hFF : sum[BYTE_W-1:0];
   endfunction

endpackage

// File: rtl/uart_cmd_dispatcher_hamming_7_4_decoder.sv
// Hamming(7,4) checker: extracts the data nibble and flags any nonzero syndrome.
module hamming_7_4_decoder (
   input  logic [6:0] code,
   output logic [3:0] data_c,
   output logic       err_c
);
   logic [2:0] syndrome;

   always_comb begin
      syndrome[0] = code[0] ^ code[2] ^ code[4] ^ code[6];
      syndrome[1] = code[1] ^ code[2] ^ code[5] ^ code[6];
      syndrome[2] = code[3] ^ code[4] ^ code[5] ^ code[6];
      data_c      = {code[6], code[5], code[4], code[2]};
      err_c       = |syndrome;
   end
endmodule

// File: rtl/uart_cmd_dispatcher.sv
// Framed address+command receiver: decodes Hamming-coded bytes, updates one
// channel enable and returns an ACK/NACK reply byte.
module uart_cmd_dispatcher
   import uart_cmd_dispatcher_pkg::*;
#(
   parameter int unsigned N_CH    = 3,
   parameter int unsigned TIMEOUT = 2400,
   parameter int unsigned ACK_EN  = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [7:0]      rx_data,
   input  logic            rx_done,
   input  logic            rx_parity_error,
   input  logic            tx_busy,
   output logic [7:0]      tx_data,
   output logic            tx_start,
   output logic [N_CH-1:0] ch_state,
   output logic            frame_ok,
   output logic            frame_err,
   output logic [7:0]      err_count
);
   localparam int unsigned      TIMER_W  = $clog2(TIMEOUT + 1);
   localparam logic [NIB_W-1:0] N_CH_NIB = NIB_W'(N_CH);
   localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT - 1);

   logic [2:0]         state_q, state_d;
   field_t             addr_q, addr_d, cmd_q, cmd_d, rx_field;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic               skip_q, skip_d;
   logic [N_CH-1:0]    ch_d;
   logic [7:0]         tx_data_d, err_count_d, reply;
   logic               tx_start_d, frame_ok_d, frame_err_d;
   logic [NIB_W-1:0]   reason;
   logic               frame_fail, drop;
   logic [1:0]         err_inc;
   logic [3:0]         dec_data;
   logic               dec_err;

   hamming_7_4_decoder u_dec (
      .code   (rx_data[6:0]),
      .data_c (dec_data),
      .err_c  (dec_err)
   );

   assign rx_field = '{nibble: dec_data, ham_err: dec_err, par_err: rx_parity_error};

   // Frame verdict, first failing check wins.
   always_comb begin
      if (addr_q.par_err || cmd_q.par_err)       reason = RSN_PAR;
      else if (addr_q.ham_err || cmd_q.ham_err)  reason = RSN_HAM;
      else if (addr_q.nibble >= N_CH_NIB)        reason = RSN_ADDR;
      else if (!is_known_cmd(cmd_q.nibble))      reason = RSN_CODE;
      else                                       reason = RSN_NONE;
      reply = (reason == RSN_NONE) ? (REPLY_ACK  | {4'h0, addr_q.nibble})
                                   : (REPLY_NACK | {4'h0, reason});
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      cmd_d      = cmd_q;
      timer_d    = timer_q;
      skip_d     = skip_q;
      ch_d       = ch_state;
      tx_data_d  = tx_data;
      tx_start_d = 1'b0;
      frame_ok_d = 1'b0;
      frame_fail = 1'b0;
      drop       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (rx_done) begin
               if (rx_data[7]) begin
                  addr_d  = rx_field;
                  timer_d = TIMER_LOAD;
                  state_d = S_WAIT_CMD;
               end else begin
                  frame_fail = 1'b1;
               end
            end
         end
         S_WAIT_CMD: begin
            // A strobe on the expiry cycle is still honoured.
            if (rx_done) begin
               if (!rx_data[7]) begin
                  cmd_d   = rx_field;
                  state_d = S_EXEC;
               end else begin
                  frame_fail = 1'b1;
                  addr_d     = rx_field;
                  timer_d    = TIMER_LOAD;
               end
            end else if (timer_q == '0) begin
               frame_fail = 1'b1;
               state_d    = S_IDLE;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         S_EXEC: begin
            drop = rx_done;
            if (reason == RSN_NONE) begin
               frame_ok_d = 1'b1;
               for (int unsigned i = 0; i < N_CH; i++) begin
                  if (addr_q.nibble == NIB_W'(i)) begin
                     case (cmd_q.nibble)
                        CMD_ON:  ch_d[i] = 1'b1;
                        CMD_OFF: ch_d[i] = 1'b0;
                        CMD_TOG: ch_d[i] = ~ch_state[i];
                        default: ch_d[i] = ch_state[i];
                     endcase
                  end
               end
            end else begin
               frame_fail = 1'b1;
            end
            if (ACK_EN != 0) begin
               tx_data_d = reply;
               if (!tx_busy) begin
                  tx_start_d = 1'b1;
                  skip_d     = 1'b1;
                  state_d    = S_WAIT_TX;
               end else begin
                  state_d = S_SEND;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SEND: begin
            drop = rx_done;
            if (!tx_busy) begin
               tx_start_d = 1'b1;
               skip_d     = 1'b1;
               state_d    = S_WAIT_TX;
            end
         end
         S_WAIT_TX: begin
            drop = rx_done;
            if (skip_q) begin
               skip_d = 1'b0;
            end else if (!tx_busy) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      err_inc     = {1'b0, frame_fail} + {1'b0, drop};
      frame_err_d = (err_inc != 2'd0);
      err_count_d = sat_add(err_count, err_inc);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         cmd_q     <= '0;
         timer_q   <= '0;
         skip_q    <= 1'b0;
         ch_state  <= '0;
         tx_data   <= '0;
         tx_start  <= 1'b0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         err_count <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         cmd_q     <= cmd_d;
         timer_q   <= timer_d;
         skip_q    <= skip_d;
         ch_state  <= ch_d;
         tx_data   <= tx_data_d;
         tx_start  <= tx_start_d;
         frame_ok  <= frame_ok_d;
         frame_err <= frame_err_d;
         err_count <= err_count_d;
      end
   end

endmodule

// File: tb/tb_uart_cmd_dispatcher.sv
// Randomized bench for uart_cmd_dispatcher with a frame-level reference model
// and a per-cycle output monitor.
module tb_uart_cmd_dispatcher;
   localparam int unsigned N_CH    = 3;
   localparam int unsigned TIMEOUT = 64;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [7:0]      rx_data = '0;
   logic            rx_done = 1'b0;
   logic            rx_parity_error = 1'b0;
   logic            tx_busy;
   logic            busy_force = 1'b0;
   logic            busy_auto = 1'b0;
   logic [7:0]      tx_data;
   logic            tx_start;
   logic [N_CH-1:0] ch_state;
   logic            frame_ok, frame_err;
   logic [7:0]      err_count;

   assign tx_busy = busy_force | busy_auto;

   uart_cmd_dispatcher #(.N_CH(N_CH), .TIMEOUT(TIMEOUT), .ACK_EN(1)) dut (
      .clk             (clk),
      .reset           (reset),
      .rx_data         (rx_data),
      .rx_done         (rx_done),
      .rx_parity_error (rx_parity_error),
      .tx_busy         (tx_busy),
      .tx_data         (tx_data),
      .tx_start        (tx_start),
      .ch_state        (ch_state),
      .frame_ok        (frame_ok),
      .frame_err       (frame_err),
      .err_count       (err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit              ok;
      logic [N_CH-1:0] ch;
      int              errc;
   } ev_t;

   ev_t             ev_q[$];
   logic [7:0]      rep_q[$];
   logic [N_CH-1:0] m_ch = '0;
   int              m_err = 0;

   int              n_cmp = 0, n_bad = 0;
   int              n_ok = 0, n_errp = 0, n_txs = 0;
   int              busy_len = 5;
   logic [N_CH-1:0] last_ch = '0;
   int              last_err = 0;
   logic [7:0]      last_tx = '0;
   logic            busy_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: encoding defined straight from the bit layout; a byte is valid iff it re-encodes to itself.
   function automatic logic [7:0] enc(input logic [3:0] n, input logic is_addr);
      logic p1, p2, p3;
      p1 = n[0] ^ n[1] ^ n[3];
      p2 = n[0] ^ n[2] ^ n[3];
      p3 = n[1] ^ n[2] ^ n[3];
      return {is_addr, n[3], n[2], n[1], p3, n[0], p2, p1};
   endfunction

   function automatic logic [3:0] nib(input logic [7:0] b);
      return {b[6], b[5], b[4], b[2]};
   endfunction

   function automatic bit valid(input logic [7:0] b);
      return enc(nib(b), b[7]) == b;
   endfunction

   task automatic push_err();
      ev_t e;
      if (m_err < 255) m_err++;
      e.ok = 1'b0; e.ch = m_ch; e.errc = m_err;
      ev_q.push_back(e);
   endtask

   task automatic model_frame(input logic [7:0] a, input bit ap, input logic [7:0] c, input bit cp);
      int         reason;
      logic [3:0] an, cn;
      ev_t        e;
      an = nib(a);
      cn = nib(c);
      if (ap || cp)                                      reason = 4;
      else if (!valid(a) || !valid(c))                   reason = 1;
      else if (32'(an) >= N_CH)                          reason = 2;
      else if (!(cn inside {4'h6, 4'hD, 4'h9, 4'h0}))    reason = 3;
      else                                               reason = 0;
      if (reason == 0) begin
         if (cn == 4'h6) m_ch[an] = 1'b1;
         else if (cn == 4'hD) m_ch[an] = 1'b0;
         else if (cn == 4'h9) m_ch[an] = ~m_ch[an];
         e.ok = 1'b1; e.ch = m_ch; e.errc = m_err;
         ev_q.push_back(e);
         rep_q.push_back(8'hA0 | {4'h0, an});
      end else begin
         push_err();
         rep_q.push_back(8'hE0 | 8'(reason));
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit par);
      rx_data = b; rx_parity_error = par; rx_done = 1'b1;
      @(posedge clk); #1;
      rx_done = 1'b0; rx_parity_error = 1'b0;
   endtask

   task automatic run_frame(input logic [7:0] a, input bit ap, input logic [7:0] c, input bit cp,
                            input int gap);
      send_byte(a, ap);
      idle(gap - 1);
      send_byte(c, cp);
      model_frame(a, ap, c, cp);
      idle(25);
   endtask

   task automatic expect_lit(input string tag, input logic [N_CH-1:0] ch, input logic [7:0] tx,
                             input int errc);
      check({tag, "_ch_state"}, 32'(ch_state), 32'(ch));
      check({tag, "_tx_data"}, 32'(last_tx), 32'(tx));
      check({tag, "_err_count"}, 32'(err_count), 32'(errc));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      busy_force = 1'b0;
      ev_q.delete(); rep_q.delete();
      m_ch = '0; m_err = 0;
      #1;
      check("rst_ch_state", 32'(ch_state), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_tx_start", 32'(tx_start), 32'd0);
      check("rst_frame_ok", 32'(frame_ok), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Stand-in for uart_tx: busy for busy_len cycles after each start strobe.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (tx_start && !reset) begin
            busy_auto = 1'b1;
            repeat (busy_len) begin @(posedge clk); #1; end
            busy_auto = 1'b0;
         end
      end
   end

   // Output monitor: every pulse must match the next modelled event; otherwise state holds.
   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            check("inreset_outputs", {7'b0, tx_start, frame_ok, frame_err, tx_data, err_count},
                  32'd0);
            last_ch = '0;
            last_err = 0;
         end else begin
            if (frame_ok || frame_err) begin
               check("pulse_exclusive", 32'(frame_ok & frame_err), 32'd0);
               if (ev_q.size() == 0) begin
                  check("unexpected_frame_pulse", {30'b0, frame_ok, frame_err}, 32'd0);
               end else begin
                  e = ev_q.pop_front();
                  check("frame_ok_kind", 32'(frame_ok), 32'(e.ok));
                  check("event_ch_state", 32'(ch_state), 32'(e.ch));
                  check("event_err_count", 32'(err_count), 32'(e.errc));
                  last_ch = e.ch;
                  last_err = e.errc;
               end
               n_ok += int'(frame_ok);
               n_errp += int'(frame_err);
            end else begin
               check("ch_state_hold", 32'(ch_state), 32'(last_ch));
               check("err_count_hold", 32'(err_count), 32'(last_err));
            end
            if (tx_start) begin
               check("tx_start_while_busy", 32'(busy_prev), 32'd0);
               if (rep_q.size() == 0) begin
                  check("unexpected_tx_start", 32'(tx_start), 32'd0);
               end else begin
                  check("tx_data_reply", 32'(tx_data), 32'(rep_q.pop_front()));
               end
               last_tx = tx_data;
               n_txs++;
            end
         end
         busy_prev = tx_busy;
      end
   end

   initial begin
      int         b_ok, b_tx, b_err, g, kind;
      logic [7:0] a, c, a2;
      bit         ap, cp;

      idle(1);
      do_reset();

      b_ok = n_ok; b_tx = n_txs;
      run_frame(8'h99, 0, 8'h33, 0, 1);
      expect_lit("on2", 3'b100, 8'hA2, 0);
      check("on2_ok_pulses", 32'(n_ok - b_ok), 32'd1);
      check("on2_tx_starts", 32'(n_txs - b_tx), 32'd1);
      run_frame(8'h99, 0, 8'h4C, 0, 3);
      expect_lit("tog2", 3'b000, 8'hA2, 0);
      run_frame(8'h99, 0, 8'h66, 0, 2);
      expect_lit("off2", 3'b000, 8'hA2, 0);
      run_frame(8'h89, 0, 8'h33, 0, 1);
      expect_lit("hamming", 3'b000, 8'hE1, 1);
      run_frame(8'hAD, 0, 8'h33, 0, 1);
      expect_lit("bad_addr", 3'b000, 8'hE2, 2);
      run_frame(8'h80, 0, 8'h00, 0, 1);
      expect_lit("ping", 3'b000, 8'hA0, 2);
      run_frame(8'h99, 0, 8'h33, 1, 1);
      expect_lit("parity", 3'b000, 8'hE4, 3);
      run_frame(8'h99, 0, 8'h2D, 0, 1);
      expect_lit("unknown", 3'b000, 8'hE3, 4);

      b_tx = n_txs; b_err = n_errp;
      send_byte(8'h99, 0);
      push_err();
      idle(TIMEOUT + 5);
      check("timeout_no_tx", 32'(n_txs - b_tx), 32'd0);
      check("timeout_err_pulse", 32'(n_errp - b_err), 32'd1);
      check("timeout_err_count", 32'(err_count), 32'd5);

      send_byte(8'h99, 0);
      idle(2);
      send_byte(8'h99, 0);
      push_err();
      idle(2);
      send_byte(8'h33, 0);
      model_frame(8'h99, 0, 8'h33, 0);
      idle(25);
      expect_lit("resync", 3'b100, 8'hA2, 6);

      run_frame(8'h99, 0, 8'h4C, 0, TIMEOUT);
      expect_lit("edge_accept", 3'b000, 8'hA2, 6);

      send_byte(8'h99, 0);
      push_err();
      idle(TIMEOUT);
      send_byte(8'h33, 0);
      push_err();
      idle(10);
      check("edge_late_ch", 32'(ch_state), 32'd0);
      check("edge_late_err", 32'(err_count), 32'd8);

      b_tx = n_txs;
      busy_force = 1'b1;
      run_frame(8'h99, 0, 8'h33, 0, 1);
      idle(25);
      check("busy_hold_no_tx", 32'(n_txs - b_tx), 32'd0);
      busy_force = 1'b0;
      idle(25);
      check("busy_release_tx", 32'(n_txs - b_tx), 32'd1);
      expect_lit("busy", 3'b100, 8'hA2, 8);

      busy_len = 50;
      b_tx = n_txs;
      send_byte(8'h99, 0);
      send_byte(8'h33, 0);
      model_frame(8'h99, 0, 8'h33, 0);
      for (int i = 0; i < 20 && n_txs == b_tx; i++) idle(1);
      check("pre_reset_tx", 32'(n_txs - b_tx), 32'd1);
      idle(3);
      do_reset();
      idle(60);

      for (int it = 0; it < 250; it++) begin
         busy_len = int'($urandom_range(1, 10));
         kind = int'($urandom_range(0, 9));
         a = enc(($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, N_CH - 1))
                                             : 4'($urandom_range(0, 15)), 1'b1);
         case ($urandom_range(0, 4))
            0:       c = enc(4'h6, 1'b0);
            1:       c = enc(4'hD, 1'b0);
            2:       c = enc(4'h9, 1'b0);
            3:       c = enc(4'h0, 1'b0);
            default: c = enc(4'($urandom_range(0, 15)), 1'b0);
         endcase
         if ($urandom_range(0, 7) == 0) a[$urandom_range(0, 6)] ^= 1'b1;
         if ($urandom_range(0, 7) == 0) c[$urandom_range(0, 6)] ^= 1'b1;
         ap = ($urandom_range(0, 9) == 0);
         cp = ($urandom_range(0, 9) == 0);
         g = ($urandom_range(0, 5) == 0) ? int'(TIMEOUT) : int'($urandom_range(1, TIMEOUT));
         if (kind <= 5) begin
            run_frame(a, ap, c, cp, g);
         end else if (kind == 6) begin
            send_byte(c, cp);
            push_err();
            idle(3);
         end else if (kind == 7) begin
            a2 = enc(4'($urandom_range(0, N_CH - 1)), 1'b1);
            send_byte(a2, 0);
            idle(int'($urandom_range(0, TIMEOUT - 1)));
            send_byte(a, ap);
            push_err();
            idle(g - 1);
            send_byte(c, cp);
            model_frame(a, ap, c, cp);
            idle(25);
         end else if (kind == 8) begin
            send_byte(a, ap);
            push_err();
            idle(TIMEOUT + int'($urandom_range(1, 8)));
         end else begin
            busy_force = 1'b1;
            run_frame(a, ap, c, cp, 1);
            send_byte(($urandom_range(0, 1) != 0) ? a : c, 0);
            push_err();
            idle(5);
            busy_force = 1'b0;
            idle(25);
         end
      end

      for (int i = 0; i < 260; i++) begin
         send_byte(enc(4'($urandom_range(0, 15)), 1'b0), 0);
         push_err();
         idle(1);
      end
      idle(5);
      check("err_count_saturated", 32'(err_count), 32'd255);

      idle(30);
      check("events_outstanding", 32'(ev_q.size()), 32'd0);
      check("replies_outstanding", 32'(rep_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
